// File: rtl/lsh_pkg.sv
// Shared types for the LSH front end: nucleotide codes, sequencer states
// and a character-to-code helper for benches and file loaders.
package lsh_pkg;

   typedef enum logic [1:0] {
      A = 2'b00,
      C = 2'b01,
      G = 2'b10,
      T = 2'b11
   } nuc_t;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      ISSUE,
      DONE
   } seq_state_t;

   // Unknown characters map to A so loaders never produce X codes.
   function automatic nuc_t ascii_to_nuc(input logic [7:0] ch);
      case (ch)
         "C", "c": return C;
         "G", "g": return G;
         "T", "t": return T;
         default:  return A;
      endcase
   endfunction

endpackage

// File: rtl/kmer_window_buf.sv
// Window storage for the k-mer sequencer: nucleotide write port, K-1 base
// carry-over to the window head, and the K-base slice read at rd_idx.
module kmer_window_buf
   import lsh_pkg::*;
#(
   parameter int WINDOW_SIZE = 128,
   parameter int K           = 16,
   localparam int IDX_W      = $clog2(WINDOW_SIZE)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [1:0]       wr_data,
   input  logic             carry,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [2*K-1:0]   rd_kmer
);

   logic [1:0] mem [WINDOW_SIZE];

   always_ff @(posedge clk) begin
      if (carry) begin
         for (int unsigned i = 0; i < K-1; i++) begin
            mem[IDX_W'(i)] <= mem[IDX_W'(WINDOW_SIZE - K + 1 + i)];
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Base at rd_idx lands in the MSBs; lanes past the window end read as 0.
   always_comb begin
      rd_kmer = '0;
      for (int unsigned j = 0; j < K; j++) begin
         if (32'(rd_idx) + j < WINDOW_SIZE) begin
            rd_kmer[2*(K-1-j) +: 2] = mem[IDX_W'(32'(rd_idx) + j)];
         end
      end
   end

endmodule

// File: rtl/kmer_window_sequencer.sv
// Packs a nucleotide stream into windows and issues every K-base k-mer of
// each window over valid/ready, carrying K-1 bases between windows.
module kmer_window_sequencer
   import lsh_pkg::*;
#(
   parameter int WINDOW_SIZE = 128,
   parameter int K           = 16,
   parameter int CNT_W       = 16,
   localparam int IDX_W      = $clog2(WINDOW_SIZE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   input  logic             nuc_valid,
   output logic             nuc_ready,
   input  logic [1:0]       nuc_data,
   input  logic             nuc_last,
   output logic             kmer_valid,
   input  logic             kmer_ready,
   output logic [2*K-1:0]   kmer_data,
   output logic [IDX_W-1:0] kmer_idx,
   output logic             kmer_last,
   output logic             win_done,
   output logic             read_done,
   output logic [CNT_W-1:0] win_count
);

   localparam int LEN_W = $clog2(WINDOW_SIZE + 1);

   seq_state_t       state, state_nx;
   logic [IDX_W-1:0] fill_cnt;
   logic [IDX_W-1:0] idx;
   logic [LEN_W-1:0] valid_len;
   logic [LEN_W-1:0] fill_len;
   logic             last_seen;
   logic             fill_end;
   logic             at_end;
   logic             carry;
   logic [2*K-1:0]   slice;

   assign fill_len = LEN_W'(fill_cnt) + LEN_W'(1);
   assign fill_end = (fill_cnt == IDX_W'(WINDOW_SIZE - 1)) || nuc_last;
   assign at_end   = (LEN_W'(idx) == valid_len - LEN_W'(K));

   kmer_window_buf #(
      .WINDOW_SIZE (WINDOW_SIZE),
      .K           (K)
   ) u_buf (
      .clk     (clk),
      .wr_en   (nuc_valid && nuc_ready),
      .wr_addr (fill_cnt),
      .wr_data (nuc_data),
      .carry   (carry),
      .rd_idx  (idx),
      .rd_kmer (slice)
   );

   assign kmer_data = kmer_valid ? slice : '0;
   assign kmer_idx  = idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      busy       = 1'b1;
      nuc_ready  = 1'b0;
      kmer_valid = 1'b0;
      kmer_last  = 1'b0;
      win_done   = 1'b0;
      read_done  = 1'b0;
      carry      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = FILL;
         end
         FILL: begin
            nuc_ready = 1'b1;
            if (nuc_valid && fill_end) begin
               state_nx = (fill_len >= LEN_W'(K)) ? ISSUE : DONE;
            end
         end
         ISSUE: begin
            kmer_valid = 1'b1;
            kmer_last  = at_end;
            if (kmer_ready && at_end) begin
               win_done = 1'b1;
               if (last_seen) begin
                  state_nx = DONE;
               end else begin
                  carry    = 1'b1;
                  state_nx = FILL;
               end
            end
         end
         DONE: begin
            read_done = 1'b1;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_cnt  <= '0;
         idx       <= '0;
         valid_len <= '0;
         last_seen <= 1'b0;
         win_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  fill_cnt  <= '0;
                  idx       <= '0;
                  win_count <= '0;
               end
            end
            FILL: begin
               if (nuc_valid) begin
                  fill_cnt <= fill_cnt + IDX_W'(1);
                  if (fill_end) begin
                     valid_len <= fill_len;
                     last_seen <= nuc_last;
                     idx       <= '0;
                  end
               end
            end
            ISSUE: begin
               if (kmer_ready) begin
                  idx <= idx + IDX_W'(1);
                  if (at_end) begin
                     if (win_count != '1) win_count <= win_count + CNT_W'(1);
                     // Carried bases occupy 0..K-2, so the next fill resumes at K-1.
                     if (!last_seen) fill_cnt <= IDX_W'(K - 1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/kmer_window_sequencer.md
Name: kmer_window_sequencer

Overview:
Controller that sequences the k-mer window datapath of the LSH front end. It accepts a read as a stream of 2-bit nucleotide codes and packs them into a WINDOW_SIZE-entry window buffer. It then issues every K-base k-mer of that window, sliding by one base, to the downstream hashing stage over a valid/ready handshake. Between windows it carries the last K-1 bases forward, so no k-mer spanning a window boundary is lost.

Parameters:
WINDOW_SIZE, 128, number of nucleotides held per window
K, 16, k-mer length in bases; legal range 2..WINDOW_SIZE
CNT_W, 16, width of the window counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin a new read; ignored unless state is IDLE
busy  out  1  high in every state except IDLE
nuc_valid  in  1  nucleotide present
nuc_ready  out  1  sequencer accepts a nucleotide
nuc_data  in  2  A=00, C=01, G=10, T=11
nuc_last  in  1  final nucleotide of the read, qualified by nuc_valid
kmer_valid  out  1  k-mer present
kmer_ready  in  1  hash stage accepts the k-mer
kmer_data  out  2*K  k-mer; base at kmer_idx in MSBs
kmer_idx  out  $clog2(WINDOW_SIZE)  start position of the k-mer within the window
kmer_last  out  1  final k-mer of the current window
win_done  out  1  one-cycle pulse on the handshake of the final k-mer of a window
read_done  out  1  one-cycle pulse when the read is complete
win_count  out  CNT_W  windows issued (≥1 k-mer) since the last start

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, fill_cnt 0, idx 0. Window storage is not reset.
- kmer_data is forced to 0 whenever kmer_valid=0.
- Handshake: a transfer occurs when valid && ready.
  - kmer_valid must not drop, and kmer_data/kmer_idx/kmer_last must stay stable, until the transfer.
  - nuc_ready is high only in FILL.
- IDLE:
  - nuc_ready=0.
  - On start: clear fill_cnt, idx and win_count; go to FILL.
- FILL:
  - Each nucleotide transfer writes window[fill_cnt] and increments fill_cnt.
  - Exit when the transfer writes index WINDOW_SIZE-1, or when nuc_last is accepted. Latch valid_len = fill_cnt+1 and last_seen = nuc_last.
  - If valid_len ≥ K: go to ISSUE with idx=0.
  - If valid_len < K: go to DONE; no k-mer is issued for this window.
- ISSUE:
  - kmer_valid=1 from the first ISSUE cycle.
  - kmer_data = {window[idx], ..., window[idx+K-1]}.
  - kmer_last = (idx == valid_len-K).
  - On a transfer: idx increments.
  - On the transfer with kmer_last=1:
    - win_done pulses and win_count increments; win_count saturates at all-ones.
    - If last_seen: go to DONE.
    - Otherwise, in the same cycle, copy window[WINDOW_SIZE-K+1 .. WINDOW_SIZE-1] to window[0 .. K-2], set fill_cnt=K-1 and go to FILL.
- DONE:
  - read_done=1 for exactly one cycle; next state IDLE.
  - busy drops together with the transition to IDLE.
- Per-window k-mer count = valid_len-K+1. Total per read = read_length-K+1 when read_length ≥ K, otherwise 0.
- Simultaneous events:
  - start while busy is ignored.
  - nuc_valid outside FILL is not consumed.
  - win_done and the return to FILL occur in the same cycle.
- Reset mid-operation: rst in any state returns the block to IDLE in the next cycle with all reset values applied. Any partial read is discarded and no done pulse is generated.

Decomposition:
- Package lsh_pkg holds:
  - nuc_t enum (A=2'b00, C=2'b01, G=2'b10, T=2'b11);
  - seq_state_t enum (IDLE, FILL, ISSUE, DONE);
  - function ascii_to_nuc for benches and file loaders.
- Sub-module kmer_window_buf holds window storage, the write port, the K-1 carry-over copy and the k-mer slice mux.
- The FSM and counters stay in kmer_window_sequencer.

Test Plan:
(bench configured with WINDOW_SIZE=8, K=4)
1. Reset: assert rst for 2 cycles during random stimulus -> all outputs 0, busy=0, nuc_ready=0.
2. Read "ACGTACGT", nuc_last on the 8th base:
   - 5 k-mers in order 0x1B, 0x6C, 0xB1, 0xC6, 0x1B with kmer_idx 0..4;
   - kmer_last and win_done on idx 4; read_done one cycle later; win_count=1.
3. 11-base read "ACGTACGTACG":
   - window 1 issues 5 k-mers;
   - carry-over "CGT" is followed by 3 new bases, so window 2 issues 3 k-mers (0x6C, 0xB1, 0xC6);
   - total 8 k-mers, win_count=2.
4. Backpressure: hold kmer_ready=0 for 3 cycles while idx=2 -> kmer_data stays 0xB1 and kmer_idx stays 2; no k-mer is skipped or duplicated.
5. Short read "ACG" with nuc_last -> kmer_valid never asserts; read_done pulses; win_count=0.
6. rst asserted while in ISSUE at idx 3 -> next cycle kmer_valid=0 and busy=0; a following start with read "TTTT" yields a single k-mer 0xFF.
